// File: rtl/regfile_write_arbiter.sv
// Two-port writeback to single-port register-file write arbiter with one-entry skid.
// Optional macro HARDWIRE_R0_EN: register 0 is hardwired to zero and requests to it are filtered.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteA,
  input  logic [ADDR_W-1:0]   WriteRegisterA,
  input  logic [DATA_W-1:0]   WriteDataA,
  input  logic                RegWriteB,
  input  logic [ADDR_W-1:0]   WriteRegisterB,
  input  logic [DATA_W-1:0]   WriteDataB,
  output logic                Stall,
  output logic [NUM_REGS-1:0] WriteEn,
  output logic [ADDR_W-1:0]   WriteAddr,
  output logic [DATA_W-1:0]   WriteData,
  output logic                Collision
);

  logic                r_skid_valid;
  logic [ADDR_W-1:0]   r_skid_addr;
  logic [DATA_W-1:0]   r_skid_data;

  logic                w_va;
  logic                w_vb;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_col;
  logic                w_skid_load;
  logic [NUM_REGS-1:0] w_en;

  assign Stall = r_skid_valid;

  // Requests to register 0 vanish before arbitration when it is hardwired.
`ifdef HARDWIRE_R0_EN
  assign w_va = RegWriteA && (WriteRegisterA != '0);
  assign w_vb = RegWriteB && (WriteRegisterB != '0);
`else
  assign w_va = RegWriteA;
  assign w_vb = RegWriteB;
`endif

  // Pending skid drains first; inputs are ignored while it does.
  always_comb begin
    w_issue     = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    w_col       = 1'b0;
    w_skid_load = 1'b0;
    if (r_skid_valid) begin
      w_issue = 1'b1;
      w_addr  = r_skid_addr;
      w_data  = r_skid_data;
    end else if (w_va && w_vb) begin
      if (WriteRegisterA == WriteRegisterB) begin
        w_issue = 1'b1;
        w_addr  = WriteRegisterB;
        w_data  = WriteDataB;
      end else begin
        w_issue     = 1'b1;
        w_addr      = WriteRegisterA;
        w_data      = WriteDataA;
        w_col       = 1'b1;
        w_skid_load = 1'b1;
      end
    end else if (w_va) begin
      w_issue = 1'b1;
      w_addr  = WriteRegisterA;
      w_data  = WriteDataA;
    end else if (w_vb) begin
      w_issue = 1'b1;
      w_addr  = WriteRegisterB;
      w_data  = WriteDataB;
    end
  end

  always_comb begin
    w_en = '0;
    if (w_issue) begin
      w_en[w_addr] = 1'b1;
    end
`ifdef HARDWIRE_R0_EN
    w_en[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      WriteEn      <= '0;
      WriteAddr    <= '0;
      WriteData    <= '0;
      Collision    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_addr  <= '0;
      r_skid_data  <= '0;
    end else begin
      WriteEn      <= w_en;
      WriteAddr    <= w_addr;
      WriteData    <= w_data;
      Collision    <= w_col;
      r_skid_valid <= w_skid_load;
      if (w_skid_load) begin
        r_skid_addr <= WriteRegisterB;
        r_skid_data <= WriteDataB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; honours HARDWIRE_R0_EN when defined.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        RegWriteA;
  logic [4:0]  WriteRegisterA;
  logic [31:0] WriteDataA;
  logic        RegWriteB;
  logic [4:0]  WriteRegisterB;
  logic [31:0] WriteDataB;
  logic        Stall;
  logic [31:0] WriteEn;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        Collision;

  int total;
  int bad;

  typedef struct {
    logic [31:0] en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        col;
    logic        stall;
  } exp_t;

  exp_t q[$];

  logic        m_sv;
  logic [4:0]  m_sa;
  logic [31:0] m_sd;

  regfile_write_arbiter #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .RegWriteA(RegWriteA), .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA),
    .RegWriteB(RegWriteB), .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB),
    .Stall(Stall), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .Collision(Collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge and queue the reference result.
  task automatic drive(input logic rst, input logic ra, input logic [4:0] aa, input logic [31:0] da,
                       input logic rb, input logic [4:0] ab, input logic [31:0] db);
    exp_t e;
    logic va;
    logic vb;
    @(negedge clk);
    reset = rst;
    RegWriteA = ra; WriteRegisterA = aa; WriteDataA = da;
    RegWriteB = rb; WriteRegisterB = ab; WriteDataB = db;
    e.en = '0; e.addr = '0; e.data = '0; e.col = 1'b0; e.stall = 1'b0;
    va = ra;
    vb = rb;
`ifdef HARDWIRE_R0_EN
    va = ra && (aa != 5'd0);
    vb = rb && (ab != 5'd0);
`endif
    if (rst) begin
      m_sv = 1'b0;
    end else if (m_sv) begin
      e.en = 32'(1) << m_sa; e.addr = m_sa; e.data = m_sd;
      m_sv = 1'b0;
    end else if (va && vb && aa == ab) begin
      e.en = 32'(1) << ab; e.addr = ab; e.data = db;
    end else if (va && vb) begin
      e.en = 32'(1) << aa; e.addr = aa; e.data = da; e.col = 1'b1;
      m_sv = 1'b1; m_sa = ab; m_sd = db;
    end else if (va) begin
      e.en = 32'(1) << aa; e.addr = aa; e.data = da;
    end else if (vb) begin
      e.en = 32'(1) << ab; e.addr = ab; e.data = db;
    end
    e.stall = m_sv;
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: each queued entry corresponds to the edge following its stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (WriteEn !== e.en) begin
        bad++; $display("FAIL sb_en got=%h exp=%h t=%0t", WriteEn, e.en, $time);
      end
      total++;
      if (Collision !== e.col) begin
        bad++; $display("FAIL sb_col got=%b exp=%b t=%0t", Collision, e.col, $time);
      end
      total++;
      if (Stall !== e.stall) begin
        bad++; $display("FAIL sb_stall got=%b exp=%b t=%0t", Stall, e.stall, $time);
      end
      if (e.en != 32'h0) begin
        total++;
        if (WriteAddr !== e.addr || WriteData !== e.data) begin
          bad++;
          $display("FAIL sb_addr_data got=%0d/%h exp=%0d/%h t=%0t", WriteAddr, WriteData, e.addr, e.data, $time);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
      settle();
      total++;
      if (WriteEn !== 32'h0 || Stall !== 1'b0 || Collision !== 1'b0) begin
        bad++; $display("FAIL reset_hold got=%h/%b/%b exp=0/0/0", WriteEn, Stall, Collision);
      end
    end
    idle();
    settle();
    total++;
    if (WriteEn !== 32'h0 || Stall !== 1'b0 || Collision !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%h/%b/%b exp=0/0/0", WriteEn, Stall, Collision);
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    settle();
    total++;
    if (WriteEn !== 32'h20 || WriteAddr !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single got=%h/%0d/%h exp=00000020/5/deadbeef", WriteEn, WriteAddr, WriteData);
    end
    idle();
    settle();
    total++;
    if (WriteEn !== 32'h0) begin
      bad++; $display("FAIL single_after got=%h exp=0", WriteEn);
    end
  endtask

  task automatic test_conflict();
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    settle();
    total++;
    if (WriteEn !== 32'h8 || Collision !== 1'b1 || Stall !== 1'b1) begin
      bad++; $display("FAIL conflict_c1 got=%h/%b/%b exp=8/1/1", WriteEn, Collision, Stall);
    end
    drive(1'b0, 1'b1, 5'd12, 32'h99, 1'b1, 5'd13, 32'h98);
    settle();
    total++;
    if (WriteEn !== 32'h80 || WriteData !== 32'h22 || Stall !== 1'b0 || Collision !== 1'b0) begin
      bad++; $display("FAIL conflict_c2 got=%h/%h/%b/%b exp=80/22/0/0", WriteEn, WriteData, Stall, Collision);
    end
    idle();
    settle();
    total++;
    if (WriteEn !== 32'h0) begin
      bad++; $display("FAIL conflict_ignored got=%h exp=0", WriteEn);
    end
  endtask

  task automatic test_waw();
    drive(1'b0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
    settle();
    total++;
    if (WriteEn !== 32'h200 || WriteData !== 32'hBB || Stall !== 1'b0 || Collision !== 1'b0) begin
      bad++; $display("FAIL waw got=%h/%h/%b/%b exp=200/bb/0/0", WriteEn, WriteData, Stall, Collision);
    end
    idle();
    settle();
    total++;
    if (WriteEn !== 32'h0) begin
      bad++; $display("FAIL waw_single got=%h exp=0", WriteEn);
    end
  endtask

  task automatic test_r0();
    drive(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd4, 32'h44);
    settle();
`ifdef HARDWIRE_R0_EN
    total++;
    if (WriteEn !== 32'h10 || WriteData !== 32'h44 || Collision !== 1'b0 || Stall !== 1'b0) begin
      bad++; $display("FAIL r0_filter got=%h/%h/%b/%b exp=10/44/0/0", WriteEn, WriteData, Collision, Stall);
    end
    idle();
    settle();
`else
    total++;
    if (WriteEn !== 32'h1 || WriteData !== 32'h55 || Collision !== 1'b1 || Stall !== 1'b1) begin
      bad++; $display("FAIL r0_c1 got=%h/%h/%b/%b exp=1/55/1/1", WriteEn, WriteData, Collision, Stall);
    end
    idle();
    settle();
    total++;
    if (WriteEn !== 32'h10 || WriteData !== 32'h44 || Stall !== 1'b0) begin
      bad++; $display("FAIL r0_c2 got=%h/%h/%b exp=10/44/0", WriteEn, WriteData, Stall);
    end
`endif
    idle();
    settle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    settle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    total++;
    if (WriteEn !== 32'h0 || Stall !== 1'b0) begin
      bad++; $display("FAIL reset_mid got=%h/%b exp=0/0", WriteEn, Stall);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      settle();
      total++;
      if (WriteEn[7] !== 1'b0) begin
        bad++; $display("FAIL reset_mid_r7 got=%h exp bit7=0", WriteEn);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      settle();
      total++;
      if ((WriteEn & (WriteEn - 32'h1)) !== 32'h0) begin
        bad++; $display("FAIL onehot got=%h exp=at most one bit", WriteEn);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_sv = 1'b0;
    m_sa = '0;
    m_sd = '0;
    reset = 1'b1;
    RegWriteA = 1'b0; WriteRegisterA = '0; WriteDataA = '0;
    RegWriteB = 1'b0; WriteRegisterB = '0; WriteDataB = '0;
    test_reset();
    test_single();
    test_conflict();
    test_waw();
    test_r0();
    test_reset_mid();
    test_random();
    idle();
    idle();
    settle();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
